// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered count, threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through reads; the default is a registered 1-cycle read.
module fifo_sync_flags #(
    parameter int FIFO_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_ena,
    input  logic [FIFO_WIDTH-1:0] wr_data,
    input  logic                  rd_ena,
    input  logic                  err_clr,
    output logic [FIFO_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_THRESH[ADDR_WIDTH:0];

    logic [FIFO_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come only from the registered count, so no input reaches them combinationally.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign wr_acc = wr_ena & ~full;
    assign rd_acc = rd_ena & ~empty;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A coinciding rejected request outranks err_clr so no error event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ena & full)       overflow <= 1'b1;
            else if (err_clr)        overflow <= 1'b0;
            if (rd_ena & empty)      underflow <= 1'b1;
            else if (err_clr)        underflow <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_valid = ~empty;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem[rd_ptr];
        end
    end
`endif

endmodule
